// File: rtl/ups_pkg.sv
// ups_pkg: types shared by the ADC front end, averager and control block
package ups_pkg;
  localparam int ADC_W = 12;
  typedef logic [ADC_W-1:0] adc_t;
endpackage

// File: rtl/ups_ring.sv
// ups_ring: circular delay line presenting the oldest entry combinationally
module ups_ring
  import ups_pkg::*;
#(
  parameter int W     = ADC_W,
  parameter int LOG2N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         we,
  input  logic [W-1:0] din,
  output logic [W-1:0] oldest
);
  logic [W-1:0]     mem [2**LOG2N];
  logic [LOG2N-1:0] wptr;
  always_ff @(posedge clk)
    if (rst || clr) begin
      for (int i = 0; i < 2**LOG2N; i++) mem[i] <= '0;
      wptr <= '0;
    end else if (we) begin
      mem[wptr] <= din;
      wptr      <= wptr + 1'b1;
    end
  assign oldest = mem[wptr];
endmodule

// File: rtl/ups_adc_avg.sv
// ups_adc_avg: boxcar average of the last 2^LOG2N ADC samples with hysteretic over/under flags
module ups_adc_avg
  import ups_pkg::*;
#(
  parameter int DW    = ADC_W,
  parameter int LOG2N = 4,
  parameter int HYST  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] adc,
  input  logic          adc_dv,
  input  logic          flush,
  input  logic [DW-1:0] thr_hi,
  input  logic [DW-1:0] thr_lo,
  input  logic          thr_update,
  output logic [DW-1:0] avg,
  output logic          avg_dv,
  output logic          primed,
  output logic          over,
  output logic          under
);
  localparam int SW = DW + LOG2N;
  localparam logic [LOG2N:0] FULL = (LOG2N+1)'(2**LOG2N);
  localparam logic [DW-1:0]  HY   = DW'(HYST);
  logic [DW-1:0]  oldest, hi_s, lo_s, avg_new, hi_clr, lo_clr;
  logic [DW:0]    lo_add;
  logic [SW-1:0]  sum, sum_next;
  logic [LOG2N:0] cnt, cnt_next;
  logic           take, fire, over_next, under_next;
  ups_ring #(.W(DW), .LOG2N(LOG2N)) u_ring (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .we     (take),
    .din    (adc),
    .oldest (oldest)
  );
  always_comb begin
    take       = adc_dv && !flush;
    sum_next   = sum + SW'(adc) - SW'(oldest);
    cnt_next   = primed ? cnt : cnt + 1'b1;
    fire       = take && cnt_next == FULL;
    avg_new    = sum_next[SW-1:LOG2N];
    hi_clr     = hi_s >= HY ? hi_s - HY : '0;
    lo_add     = {1'b0, lo_s} + {1'b0, HY};
    lo_clr     = lo_add[DW] ? '1 : lo_add[DW-1:0];
    over_next  = avg_new >= hi_s ? 1'b1 : avg_new < hi_clr ? 1'b0 : over;
    under_next = avg_new <= lo_s ? 1'b1 : avg_new > lo_clr ? 1'b0 : under;
  end
  assign primed = cnt == FULL;
  always_ff @(posedge clk)
    if (rst) begin
      sum    <= '0;
      cnt    <= '0;
      avg    <= '0;
      avg_dv <= 1'b0;
      over   <= 1'b0;
      under  <= 1'b0;
      hi_s   <= '1;
      lo_s   <= '0;
    end else begin
      avg_dv <= fire;
      if (thr_update) begin
        hi_s <= thr_hi;
        lo_s <= thr_lo;
      end
      if (flush) begin
        sum   <= '0;
        cnt   <= '0;
        over  <= 1'b0;
        under <= 1'b0;
      end else if (adc_dv) begin
        sum <= sum_next;
        cnt <= cnt_next;
        if (fire) begin
          avg   <= avg_new;
          over  <= over_next;
          under <= under_next;
        end
      end
    end
endmodule

// File: tb/tb_ups_adc_avg.sv
// tb_ups_adc_avg: directed and randomized checks of ups_adc_avg against a window-queue model
module tb_ups_adc_avg;
  logic        clk = 1'b0;
  logic        rst, adc_dv, flush, thr_update;
  logic [11:0] adc, thr_hi, thr_lo, avg;
  logic        avg_dv, primed, over, under;
  int checks = 0, errors = 0;
  int win[$];
  int m_avg, m_hi, m_lo;
  bit m_dv, m_over, m_under;

  always #5 clk = ~clk;

  ups_adc_avg #(.DW(12), .LOG2N(4), .HYST(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .adc        (adc),
    .adc_dv     (adc_dv),
    .flush      (flush),
    .thr_hi     (thr_hi),
    .thr_lo     (thr_lo),
    .thr_update (thr_update),
    .avg        (avg),
    .avg_dv     (avg_dv),
    .primed     (primed),
    .over       (over),
    .under      (under)
  );

  task automatic chk(input string tag, input logic [15:0] got, input int exp);
    checks++;
    assert (got === 16'(exp)) else begin
      errors++;
      $error("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("avg", {4'b0, avg}, m_avg);
    chk("avg_dv", {15'b0, avg_dv}, int'(m_dv));
    chk("primed", {15'b0, primed}, int'(win.size() == 16));
    chk("over", {15'b0, over}, int'(m_over));
    chk("under", {15'b0, under}, int'(m_under));
  endtask

  task automatic model(input bit dv, input int a, input bit fl, input bit tu, input int th, input int tl);
    int s;
    m_dv = 0;
    if (fl) begin
      win.delete();
      m_over  = 0;
      m_under = 0;
    end else if (dv) begin
      win.push_back(a);
      if (win.size() > 16) void'(win.pop_front());
      if (win.size() == 16) begin
        s = 0;
        foreach (win[i]) s += win[i];
        m_avg = s / 16;
        m_dv  = 1;
        if (m_avg >= m_hi) m_over = 1;
        else if (m_avg < ((m_hi - 8 < 0) ? 0 : m_hi - 8)) m_over = 0;
        if (m_avg <= m_lo) m_under = 1;
        else if (m_avg > ((m_lo + 8 > 4095) ? 4095 : m_lo + 8)) m_under = 0;
      end
    end
    if (tu) begin
      m_hi = th;
      m_lo = tl;
    end
  endtask

  task automatic step(input bit dv, input int a, input bit fl, input bit tu, input int th, input int tl);
    @(negedge clk);
    rst        = 1'b0;
    adc_dv     = dv;
    adc        = 12'(a);
    flush      = fl;
    thr_update = tu;
    thr_hi     = 12'(th);
    thr_lo     = 12'(tl);
    @(posedge clk);
    model(dv, a & 'hFFF, fl, tu, th & 'hFFF, tl & 'hFFF);
    #1 check_all();
  endtask

  task automatic sample(input int a);
    step(1, a, 0, 0, int'($urandom), int'($urandom));
  endtask

  task automatic idle();
    step(0, int'($urandom), 0, 0, int'($urandom), int'($urandom));
  endtask

  task automatic upd(input int th, input int tl);
    step(0, int'($urandom), 0, 1, th, tl);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    adc_dv     = 1'b1;
    adc        = 12'(int'($urandom));
    flush      = 1'b0;
    thr_update = 1'b1;
    thr_hi     = 12'h123;
    thr_lo     = 12'h456;
    @(posedge clk);
    win.delete();
    m_avg = 0; m_dv = 0; m_over = 0; m_under = 0; m_hi = 'hFFF; m_lo = 0;
    #1 check_all();
  endtask

  initial begin
    rst = 1'b1; adc_dv = 0; flush = 0; thr_update = 0; adc = 0; thr_hi = 0; thr_lo = 0;
    do_reset();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i != 0) repeat (4) idle();
      sample('h100);
    end
    chk("prime_avg", {4'b0, avg}, 'h100);
    chk("prime_dv", {15'b0, avg_dv}, 1);
    chk("prime_primed", {15'b0, primed}, 1);
    for (int i = 0; i < 16; i++) begin
      sample('h200);
      chk("step_avg", {4'b0, avg}, 'h100 + 'h10 * (i + 1));
    end
    upd('h180, 0);
    repeat (16) sample('h180);
    chk("ov_180", {15'b0, over}, 1);
    sample('h140);
    chk("ov_17c_avg", {4'b0, avg}, 'h17C);
    chk("ov_17c", {15'b0, over}, 1);
    sample('h140);
    chk("ov_178", {15'b0, over}, 1);
    sample('h170);
    chk("ov_177_avg", {4'b0, avg}, 'h177);
    chk("ov_177", {15'b0, over}, 0);
    upd('hFFF, 'hFFC);
    sample('hFFF);
    chk("un_set", {15'b0, under}, 1);
    repeat (20) sample('hFFF);
    chk("un_clamp_avg", {4'b0, avg}, 'hFFF);
    chk("un_clamp", {15'b0, under}, 1);
    upd('hFFF, 0);
    repeat (16) sample('h200);
    chk("fl_pre_avg", {4'b0, avg}, 'h200);
    step(1, 'h300, 1, 0, int'($urandom), int'($urandom));
    chk("fl_primed", {15'b0, primed}, 0);
    chk("fl_over", {15'b0, over}, 0);
    chk("fl_under", {15'b0, under}, 0);
    for (int i = 0; i < 16; i++) begin
      sample('h300);
      chk("fl_dv", {15'b0, avg_dv}, int'(i == 15));
    end
    chk("fl_avg", {4'b0, avg}, 'h300);
    repeat (4) sample('h300);
    step(1, 'h300, 0, 1, 0, 0);
    chk("upd_same", {15'b0, over}, 0);
    sample('h300);
    chk("upd_next", {15'b0, over}, 1);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      sample('hFFF);
      if (i >= 15) begin
        chk("fr_dv", {15'b0, avg_dv}, 1);
        chk("fr_avg", {4'b0, avg}, 'hFFF);
      end
    end
    repeat (5) sample('h555);
    do_reset();
    chk("rst_mid_primed", {15'b0, primed}, 0);
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r == 99) do_reset();
      else step($urandom_range(0, 2) != 0, int'($urandom_range(0, 4095)), r < 3,
                r >= 3 && r < 10, int'($urandom_range(1900, 2200)), int'($urandom_range(1900, 2200)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
